// File: rtl/step_tick_pkg.sv
// rtl/step_tick_pkg.sv - shared mode type, default timing constants and width helper for step_tick_gen
package step_tick_pkg;

  // Operating mode of the tick generator
  typedef enum logic {
    STEP = 1'b0,
    RUN  = 1'b1
  } mode_t;

  // 50 MHz board clock: 25e6 cycles per run tick, 10 ms debounce window
  localparam int DIV_MAX_DEFAULT   = 24999999;
  localparam int DB_CYCLES_DEFAULT = 500000;

  // Bits needed to hold 0..max_val, never less than one bit
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronizer plus stability-window debouncer for a raw push-button
module btn_debounce
  import step_tick_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level
);

  localparam int              DBW     = cnt_width(DB_CYCLES);
  localparam logic [DBW-1:0]  DB_LAST = DBW'(DB_CYCLES - 1);

  logic           btn_s1;
  logic           btn_s2;
  logic [DBW-1:0] db_cnt;

  // Bring the asynchronous button into the clk domain
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
    end
  end

  // Accept a new level only after it has differed from the current one for DB_CYCLES cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt    <= '0;
      btn_level <= 1'b0;
    end else if (btn_s2 == btn_level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      btn_level <= btn_s2;
      db_cnt    <= '0;
    end else begin
      db_cnt <= db_cnt + DBW'(1);
    end
  end

endmodule

// File: rtl/step_tick_gen.sv
// rtl/step_tick_gen.sv - free-run / single-step tick and slow clock source for a JK counter demo
module step_tick_gen
  import step_tick_pkg::*;
#(
  parameter int DIV_MAX   = DIV_MAX_DEFAULT,
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic step_btn,
  output logic tick,
  output logic slow_clk,
  output logic btn_level,
  output logic mode_run
);

  localparam int             PW       = cnt_width(DIV_MAX);
  localparam logic [PW-1:0]  PRE_LAST = PW'(DIV_MAX);

  logic          run_s1;
  logic          run_s2;
  mode_t         state;
  mode_t         state_q;
  mode_t         state_nx;
  logic          btn_prev;
  logic [PW-1:0] pre_cnt;
  logic [PW-1:0] pre_nx;
  logic          tick_nx;
  logic          mode_chg;
  logic          btn_rise;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (step_btn),
    .btn_level (btn_level)
  );

  // Bring the asynchronous mode switch into the clk domain
  always_ff @(posedge clk) begin
    if (rst) begin
      run_s1 <= 1'b0;
      run_s2 <= 1'b0;
    end else begin
      run_s1 <= run;
      run_s2 <= run_s1;
    end
  end

  // Mode register plus a one-cycle-late copy used to spot the first cycle of a new mode
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= STEP;
      state_q <= STEP;
    end else begin
      state   <= state_nx;
      state_q <= state;
    end
  end

  // Next mode, prescaler advance and tick request; the first cycle of any mode is kept quiet
  always_comb begin
    state_nx = run_s2 ? RUN : STEP;
    mode_chg = (state != state_q);
    btn_rise = btn_level & ~btn_prev;
    pre_nx   = '0;
    tick_nx  = 1'b0;
    case (state)
      RUN: begin
        if (!mode_chg) begin
          if (pre_cnt == PRE_LAST) begin
            tick_nx = 1'b1;
          end else begin
            pre_nx = pre_cnt + PW'(1);
          end
        end
      end
      default: begin
        tick_nx = btn_rise & ~mode_chg;
      end
    endcase
  end

  // Registered tick, slow clock toggle, prescaler and button edge history
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt  <= '0;
      tick     <= 1'b0;
      slow_clk <= 1'b0;
      btn_prev <= 1'b0;
    end else begin
      pre_cnt  <= pre_nx;
      tick     <= tick_nx;
      btn_prev <= btn_level;
      if (tick_nx) begin
        slow_clk <= ~slow_clk;
      end
    end
  end

  assign mode_run = (state == RUN);

endmodule

// File: tb/tb_step_tick_gen.sv
// tb/tb_step_tick_gen.sv - self-checking bench for step_tick_gen with small divider and debounce values
module tb_step_tick_gen;

  localparam int DIV_MAX   = 4;
  localparam int DB_CYCLES = 3;

  logic clk = 1'b0;
  logic rst;
  logic run;
  logic step_btn;
  logic tick;
  logic slow_clk;
  logic btn_level;
  logic mode_run;

  step_tick_gen #(
    .DIV_MAX   (DIV_MAX),
    .DB_CYCLES (DB_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .step_btn  (step_btn),
    .tick      (tick),
    .slow_clk  (slow_clk),
    .btn_level (btn_level),
    .mode_run  (mode_run)
  );

  always #5 clk = ~clk;

  // Edge counter: sampled between edges it equals the number of rising edges so far
  int   cyc = 0;
  logic rst_seen = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_q[$];
  logic exp_slow = 1'b0;
  logic mon_exp_tick;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Scoreboard: tick must appear exactly on the queued edge numbers, slow_clk toggles with each
  always @(negedge clk) begin
    if (rst_seen) begin
      exp_slow     = 1'b0;
      mon_exp_tick = 1'b0;
    end else if (exp_q.size() > 0 && exp_q[0] == cyc) begin
      mon_exp_tick = 1'b1;
      void'(exp_q.pop_front());
      exp_slow = ~exp_slow;
    end else begin
      mon_exp_tick = 1'b0;
    end
    check("tick", {31'd0, tick}, {31'd0, mon_exp_tick});
    check("slow_clk", {31'd0, slow_clk}, {31'd0, exp_slow});
  end

  typedef struct packed {
    logic rst;
    logic run;
    logic btn;
    logic exp_bl;
    logic exp_mr;
  } vec_t;

  vec_t vecs [0:7];

  initial begin
    int e;
    // Reset with run and button both asserted, then release and watch the pipelines fill
    vecs[0] = '{rst: 1'b1, run: 1'b1, btn: 1'b1, exp_bl: 1'b0, exp_mr: 1'b0};
    vecs[1] = '{rst: 1'b1, run: 1'b1, btn: 1'b1, exp_bl: 1'b0, exp_mr: 1'b0};
    vecs[2] = '{rst: 1'b1, run: 1'b1, btn: 1'b1, exp_bl: 1'b0, exp_mr: 1'b0};
    vecs[3] = '{rst: 1'b0, run: 1'b1, btn: 1'b1, exp_bl: 1'b0, exp_mr: 1'b0};
    vecs[4] = '{rst: 1'b0, run: 1'b1, btn: 1'b1, exp_bl: 1'b0, exp_mr: 1'b0};
    vecs[5] = '{rst: 1'b0, run: 1'b1, btn: 1'b1, exp_bl: 1'b0, exp_mr: 1'b1};
    vecs[6] = '{rst: 1'b0, run: 1'b1, btn: 1'b1, exp_bl: 1'b0, exp_mr: 1'b1};
    vecs[7] = '{rst: 1'b0, run: 1'b1, btn: 1'b1, exp_bl: 1'b1, exp_mr: 1'b1};

    rst      = 1'b1;
    run      = 1'b1;
    step_btn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      rst      = vecs[i].rst;
      run      = vecs[i].run;
      step_btn = vecs[i].btn;
      if (i == 3) begin
        // mode_run rises 3 edges after release, first tick 6 edges later, then every 5
        e = cyc;
        exp_q.push_back(e + 9);
        exp_q.push_back(e + 14);
        exp_q.push_back(e + 19);
        exp_q.push_back(e + 24);
      end
      wait_cycles(1);
      check($sformatf("vec%0d btn_level", i), {31'd0, btn_level}, {31'd0, vecs[i].exp_bl});
      check($sformatf("vec%0d mode_run", i), {31'd0, mode_run}, {31'd0, vecs[i].exp_mr});
    end

    // Free run through four ticks, then drop run two cycles after a tick
    wait_cycles(20);
    check("run mode_run", {31'd0, mode_run}, 32'd1);
    run = 1'b0;
    wait_cycles(2);
    check("drop mode_run still 1", {31'd0, mode_run}, 32'd1);
    wait_cycles(1);
    check("drop mode_run 0", {31'd0, mode_run}, 32'd0);

    // Release the button held since reset: level falls after 5 edges, no tick
    step_btn = 1'b0;
    wait_cycles(4);
    check("release bl held", {31'd0, btn_level}, 32'd1);
    wait_cycles(1);
    check("release bl fell", {31'd0, btn_level}, 32'd0);
    wait_cycles(3);

    // Clean press in STEP: level after 5 edges, one tick on the next
    e = cyc;
    step_btn = 1'b1;
    exp_q.push_back(e + 6);
    wait_cycles(4);
    check("press bl early", {31'd0, btn_level}, 32'd0);
    wait_cycles(1);
    check("press bl rose", {31'd0, btn_level}, 32'd1);
    wait_cycles(5);
    step_btn = 1'b0;
    wait_cycles(8);

    // Back to RUN: prescaler restarts from zero; a press while running gives no tick
    e = cyc;
    run = 1'b1;
    exp_q.push_back(e + 9);
    exp_q.push_back(e + 14);
    wait_cycles(3);
    check("rerun mode_run", {31'd0, mode_run}, 32'd1);
    step_btn = 1'b1;
    wait_cycles(11);
    check("run press bl", {31'd0, btn_level}, 32'd1);
    run = 1'b0;
    wait_cycles(3);
    check("second drop mode_run", {31'd0, mode_run}, 32'd0);
    step_btn = 1'b0;
    wait_cycles(8);
    check("second release bl", {31'd0, btn_level}, 32'd0);

    // Bounce: 2-cycle pulses never satisfy the window, only the final hold counts
    for (int k = 0; k < 6; k++) begin
      step_btn = (k % 2 == 0);
      wait_cycles(2);
    end
    check("bounce bl", {31'd0, btn_level}, 32'd0);
    e = cyc;
    step_btn = 1'b1;
    exp_q.push_back(e + 6);
    wait_cycles(4);
    check("bounce hold bl early", {31'd0, btn_level}, 32'd0);
    wait_cycles(1);
    check("bounce hold bl rose", {31'd0, btn_level}, 32'd1);
    wait_cycles(1);
    step_btn = 1'b0;
    wait_cycles(8);

    // Reset while db_cnt=2: press abandoned, resumes once reset is released
    step_btn = 1'b1;
    wait_cycles(4);
    rst = 1'b1;
    wait_cycles(1);
    check("midrst bl", {31'd0, btn_level}, 32'd0);
    check("midrst mode_run", {31'd0, mode_run}, 32'd0);
    wait_cycles(1);
    e = cyc;
    rst = 1'b0;
    exp_q.push_back(e + 6);
    wait_cycles(4);
    check("postrst bl early", {31'd0, btn_level}, 32'd0);
    wait_cycles(1);
    check("postrst bl rose", {31'd0, btn_level}, 32'd1);
    wait_cycles(4);

    check("pending ticks", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
